mem_rr_arbiter: RTL and testbench
=================================

# mem_rr_arbiter

Round-robin arbiter that shares the single physical-memory port among NUM_REQ line-level requesters (I-cache, D-cache, write-back buffer). It sits between the cache miss controllers and physical memory. It latches the winning request, holds the memory command stable until `mem_resp`, and steers the response back to the winner. A mandatory recovery cycle follows each transaction, and a sticky watchdog flags a memory that never responds.

## Interface
- NUM_REQ, 3, number of requesters (2..8); index 0 = I-cache, 1 = D-cache, 2 = write-back buffer
- ADDR_W, 16, line address width
- DATA_W, 128, line width (lc3b_line)
- TIMEOUT, 255, BUSY cycles without `mem_resp` before `timeout_err` sets

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_read  in  NUM_REQ  per-requester read request, level
- req_write  in  NUM_REQ  per-requester write request, level
- req_addr  in  NUM_REQ*ADDR_W  flattened addresses; requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*DATA_W  flattened write data, same packing
- req_resp  out  NUM_REQ  one-hot completion pulse to the winner
- req_rdata  out  DATA_W  = mem_rdata, broadcast to all requesters
- mem_read  out  1  memory read command
- mem_write  out  1  memory write command
- mem_address  out  ADDR_W  latched address
- mem_wdata  out  DATA_W  latched write data
- mem_resp  in  1  memory completion, single-cycle
- mem_rdata  in  DATA_W  memory read data, valid with mem_resp
- grant_id  out  $clog2(NUM_REQ)  current winner index; valid while busy=1
- busy  out  1  high in BUSY
- timeout_err  out  1  sticky watchdog flag

## Operation
States:
- IDLE: arbitration state.
  - Requester i is active if req_read[i] | req_write[i].
  - Winner = first active index scanning ptr+1, ptr+2, … modulo NUM_REQ.
  - On a winner, register grant_id, op, address and wdata. op = write if req_write[i], else read; write wins if both are high.
  - Clear wait_cnt. Next state BUSY.
  - No active requester: stay in IDLE.
- BUSY:
  - mem_read = (op==read); mem_write = (op==write). Both come from registered op.
  - mem_address and mem_wdata are held from the registers, not from the live req_* inputs.
  - On mem_resp: req_resp[grant_id] = 1 combinationally in the same cycle. ptr <= grant_id. Next state DONE.
  - Otherwise wait_cnt increments, saturating at TIMEOUT. When wait_cnt == TIMEOUT, timeout_err <= 1.
  - The block keeps waiting after a timeout; it never aborts.
- DONE: one recovery cycle. No mem command, no req_resp, no arbitration. Next state IDLE. This lets the winner drop its request.

Rules:
- Request deassertion during BUSY is ignored. The transaction completes and req_resp is still pulsed.
- Changes on req_addr/req_wdata during BUSY do not reach memory.
- mem_resp outside BUSY is ignored.
- req_resp is never multi-hot. It is asserted only in BUSY and only with mem_resp.
- The pointer updates only on completion, so a requester that is granted and then drops its request still counts for fairness.

Reset (rst_n low, asynchronous, at any time including mid-BUSY):
- state = IDLE, ptr = NUM_REQ-1 (requester 0 wins first).
- grant_id = 0, op = read, address/wdata registers = 0, wait_cnt = 0, timeout_err = 0.
- Hence mem_read = mem_write = busy = 0 and req_resp = 0 immediately.
- The in-flight transaction is dropped without a response.

## Timing
- Request sampled in IDLE at edge t. mem_read/mem_write high from cycle t+1.
- mem_resp in cycle k gives req_resp in cycle k (zero latency).
- DONE is cycle k+1; IDLE arbitrates in cycle k+2; the next command is issued in cycle k+3.
- Minimum transaction with mem_resp in the first BUSY cycle: 3 cycles, IDLE to BUSY to DONE.
- With two requesters continuously active, grants strictly alternate. Worst-case wait is NUM_REQ-1 transactions.
- timeout_err rises on the edge after the BUSY cycle in which wait_cnt == TIMEOUT.

## Test plan
- Reset then single read: req_read=3'b001, addr0=16'h1230; mem_resp after 4 BUSY cycles with rdata=128'hA5… gives mem_read high 4 cycles, mem_address=16'h1230, req_resp=3'b001 in the resp cycle, req_rdata=128'hA5…, busy low in DONE.
- Contention: all three requesters held active, mem_resp after 1 BUSY cycle each, gives grant order 0,1,2,0,1,2 and exactly one req_resp bit per completion.
- Stability: after grant, change req_addr1 to 16'hFFFF and drop req_write[1] gives mem_address and mem_write unchanged until mem_resp, and req_resp[1] still pulses.
- Read+write both high on requester 2 with wdata=128'h5A… gives mem_write=1, mem_read=0, mem_wdata=128'h5A….
- Watchdog: TIMEOUT=8, no mem_resp gives timeout_err rising after the 9th BUSY cycle (wait_cnt == 8), staying high; a later mem_resp still completes normally with timeout_err still 1.
- Async reset: assert rst_n=0 mid-BUSY off-edge gives mem_read, busy and req_resp low before the next clk edge; after release, requester 0 wins first.

Source files
------------

// File: rtl/mem_rr_arbiter_if.sv
// Requester-side and memory-side signals of the round-robin memory-port arbiter.
interface mem_rr_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 128
);
    localparam int GID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_read;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_resp;
    logic [DATA_W-1:0]         req_rdata;
    logic                      mem_read;
    logic                      mem_write;
    logic [ADDR_W-1:0]         mem_address;
    logic [DATA_W-1:0]         mem_wdata;
    logic                      mem_resp;
    logic [DATA_W-1:0]         mem_rdata;
    logic [GID_W-1:0]          grant_id;
    logic                      busy;
    logic                      timeout_err;

    modport slave (
        input  req_read, req_write, req_addr, req_wdata, mem_resp, mem_rdata,
        output req_resp, req_rdata, mem_read, mem_write, mem_address, mem_wdata,
        output grant_id, busy, timeout_err
    );

    modport master (
        output req_read, req_write, req_addr, req_wdata, mem_resp, mem_rdata,
        input  req_resp, req_rdata, mem_read, mem_write, mem_address, mem_wdata,
        input  grant_id, busy, timeout_err
    );
endinterface

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one physical-memory port among cache-level requesters,
// with a recovery cycle after each transaction and a sticky no-response watchdog.
module mem_rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 128,
    parameter int TIMEOUT = 255
) (
    input logic              clk,
    input logic              rst_n,
    mem_rr_arbiter_if.slave  bus
);
    localparam int GID_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t              state;
    logic [GID_W-1:0]    ptr;
    logic [GID_W-1:0]    grant_id;
    logic [GID_W-1:0]    win;
    logic [GID_W-1:0]    idx;
    logic                found;
    logic                mem_read;
    logic                mem_write;
    logic                busy;
    logic                timeout_err;
    logic [ADDR_W-1:0]   address;
    logic [DATA_W-1:0]   wdata;
    logic [CNT_W-1:0]    wait_cnt;
    logic [NUM_REQ-1:0]  active;
    logic [NUM_REQ-1:0]  req_resp;

    assign active = bus.req_read | bus.req_write;

    // Scan ptr+1, ptr+2, ... so the last completed requester has lowest priority.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = GID_W'((int'(ptr) + k) % NUM_REQ);
            if (!found && active[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        req_resp = '0;
        if (state == BUSY && bus.mem_resp)
            req_resp[grant_id] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= GID_W'(NUM_REQ - 1);
            grant_id    <= '0;
            address     <= '0;
            wdata       <= '0;
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state     <= BUSY;
                        grant_id  <= win;
                        address   <= bus.req_addr[int'(win)*ADDR_W +: ADDR_W];
                        wdata     <= bus.req_wdata[int'(win)*DATA_W +: DATA_W];
                        wait_cnt  <= '0;
                        busy      <= 1'b1;
                        mem_write <= bus.req_write[win];
                        mem_read  <= !bus.req_write[win];
                    end
                end
                BUSY: begin
                    if (bus.mem_resp) begin
                        state     <= DONE;
                        ptr       <= grant_id;
                        busy      <= 1'b0;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                    end else if (wait_cnt == CNT_W'(TIMEOUT)) begin
                        // Flag only; the transaction keeps waiting for memory.
                        timeout_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_resp    = req_resp;
    assign bus.req_rdata   = bus.mem_rdata;
    assign bus.mem_read    = mem_read;
    assign bus.mem_write   = mem_write;
    assign bus.mem_address = address;
    assign bus.mem_wdata   = wdata;
    assign bus.grant_id    = grant_id;
    assign bus.busy        = busy;
    assign bus.timeout_err = timeout_err;
endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Bench for mem_rr_arbiter: directed scenarios plus randomized traffic against a
// transaction-level reference model compared every cycle.
module tb_mem_rr_arbiter;
    localparam int NUM_REQ = 3;
    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 128;
    localparam int TIMEOUT = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_rr_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

    mem_rr_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_err    = 0;
    bit cmp_on   = 1'b0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    // Reference model: phase 0 = arbitrating, 1 = transaction outstanding, 2 = recovery.
    int                m_ph, m_ptr, m_gid, m_wcnt, m_win;
    logic              m_wr, m_terr;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;

    function automatic int pick(input int p, input logic [NUM_REQ-1:0] act);
        for (int k = 1; k <= NUM_REQ; k++)
            if (((act >> ((p + k) % NUM_REQ)) & 1) != 0) return (p + k) % NUM_REQ;
        return -1;
    endfunction

    always_comb m_win = pick(m_ptr, bus.req_read | bus.req_write);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ph <= 0; m_ptr <= NUM_REQ - 1; m_gid <= 0; m_wcnt <= 0;
            m_wr <= 1'b0; m_terr <= 1'b0; m_addr <= '0; m_wdata <= '0;
        end else if (m_ph == 0) begin
            if (m_win >= 0) begin
                m_ph    <= 1;
                m_gid   <= m_win;
                m_wr    <= ((bus.req_write >> m_win) & 1) != 0;
                m_addr  <= ADDR_W'(bus.req_addr >> (m_win * ADDR_W));
                m_wdata <= DATA_W'(bus.req_wdata >> (m_win * DATA_W));
                m_wcnt  <= 0;
            end
        end else if (m_ph == 1) begin
            if (bus.mem_resp) begin
                m_ph  <= 2;
                m_ptr <= m_gid;
            end else begin
                m_wcnt <= m_wcnt + 1;
                if (m_wcnt + 1 > TIMEOUT) m_terr <= 1'b1;
            end
        end else begin
            m_ph <= 0;
        end
    end

    always @(negedge clk) begin
        if (cmp_on && rst_n) begin
            chk("busy", bus.busy, m_ph == 1);
            chk("mem_read", bus.mem_read, m_ph == 1 && !m_wr);
            chk("mem_write", bus.mem_write, m_ph == 1 && m_wr);
            chk("req_resp", bus.req_resp, (m_ph == 1 && bus.mem_resp) ? NUM_REQ'(1 << m_gid) : '0);
            chk("req_rdata", bus.req_rdata, bus.mem_rdata);
            chk("timeout_err", bus.timeout_err, m_terr);
            if (m_ph == 1) begin
                chk("grant_id", bus.grant_id, m_gid);
                chk("mem_address", bus.mem_address, m_addr);
                chk("mem_wdata", bus.mem_wdata, m_wdata);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_busy();
        int n = 0;
        while (bus.busy !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("wait_busy", bus.busy, 1'b1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // Respond in BUSY cycle dly+1; returns DUT and model grant seen in the response cycle.
    task automatic do_txn(input int dly, output int gid, output int mg);
        wait_busy();
        repeat (dly) step();
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        gid = int'(bus.grant_id);
        mg  = m_gid;
        step();
        bus.mem_resp = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation still running, required finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        int g, mg, rd_cnt;
        int order[6] = '{0, 1, 2, 0, 1, 2};

        bus.req_read = '0; bus.req_write = '0; bus.req_addr = '0; bus.req_wdata = '0;
        bus.mem_resp = 1'b0; bus.mem_rdata = '0;

        repeat (3) @(negedge clk);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_mem_read", bus.mem_read, 1'b0);
        chk("rst_mem_write", bus.mem_write, 1'b0);
        chk("rst_req_resp", bus.req_resp, 3'b000);
        chk("rst_timeout_err", bus.timeout_err, 1'b0);
        chk("rst_mem_address", bus.mem_address, 16'h0000);
        chk("rst_grant_id", bus.grant_id, 2'd0);
        step();
        rst_n  = 1'b1;
        cmp_on = 1'b1;

        // Single read, response in the fourth BUSY cycle.
        bus.req_read = 3'b001;
        bus.req_addr = {16'h0000, 16'h0000, 16'h1230};
        step();
        rd_cnt = 0;
        for (int i = 1; i <= 4; i++) begin
            if (i == 4) begin
                bus.mem_resp  = 1'b1;
                bus.mem_rdata = {16{8'hA5}};
            end
            @(negedge clk);
            if (bus.mem_read === 1'b1) rd_cnt++;
            chk("rd_address", bus.mem_address, 16'h1230);
            if (i == 4) begin
                chk("rd_req_resp", bus.req_resp, 3'b001);
                chk("rd_req_rdata", bus.req_rdata, {16{8'hA5}});
            end
            step();
        end
        bus.mem_resp = 1'b0;
        bus.req_read = '0;
        @(negedge clk);
        chk("rd_done_busy", bus.busy, 1'b0);
        chk("rd_done_mem_read", bus.mem_read, 1'b0);
        chk("rd_read_cycles", rd_cnt, 4);
        step();

        // Contention: all three active, single-cycle responses.
        do_reset();
        bus.req_read = 3'b111;
        bus.req_addr = {16'h3333, 16'h2222, 16'h1111};
        for (int i = 0; i < 6; i++) begin
            do_txn(0, g, mg);
            chk("cont_grant", g, order[i]);
            chk("cont_model_grant", mg, order[i]);
        end
        bus.req_read = '0;

        // Stability: request 1 changes address and drops its write mid-transaction.
        bus.req_write = 3'b010;
        bus.req_addr  = {16'h0000, 16'h1111, 16'h0000};
        bus.req_wdata = {128'h0, {4{32'hCAFE_0001}}, 128'h0};
        wait_busy();
        @(negedge clk);
        chk("stab_grant", bus.grant_id, 2'd1);
        chk("stab_write0", bus.mem_write, 1'b1);
        step();
        bus.req_addr  = {16'h0000, 16'hFFFF, 16'h0000};
        bus.req_write = '0;
        step();
        @(negedge clk);
        chk("stab_address", bus.mem_address, 16'h1111);
        chk("stab_write1", bus.mem_write, 1'b1);
        step();
        bus.mem_resp = 1'b1;
        @(negedge clk);
        chk("stab_req_resp", bus.req_resp, 3'b010);
        step();
        bus.mem_resp = 1'b0;

        // Read and write both high on requester 2: write wins.
        bus.req_read  = 3'b100;
        bus.req_write = 3'b100;
        bus.req_wdata = {{16{8'h5A}}, 128'h0, 128'h0};
        wait_busy();
        @(negedge clk);
        chk("rw_mem_write", bus.mem_write, 1'b1);
        chk("rw_mem_read", bus.mem_read, 1'b0);
        chk("rw_mem_wdata", bus.mem_wdata, {16{8'h5A}});
        chk("rw_grant", bus.grant_id, 2'd2);
        step();
        bus.mem_resp = 1'b1;
        @(negedge clk);
        chk("rw_req_resp", bus.req_resp, 3'b100);
        step();
        bus.mem_resp  = 1'b0;
        bus.req_read  = '0;
        bus.req_write = '0;

        // Watchdog: no response for nine BUSY cycles.
        bus.req_read = 3'b001;
        wait_busy();
        bus.req_read = '0;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            chk("wd_before", bus.timeout_err, 1'b0);
            step();
        end
        @(negedge clk);
        chk("wd_rise", bus.timeout_err, 1'b1);
        repeat (3) step();
        @(negedge clk);
        chk("wd_sticky", bus.timeout_err, 1'b1);
        chk("wd_still_busy", bus.busy, 1'b1);
        step();
        bus.mem_resp = 1'b1;
        @(negedge clk);
        chk("wd_late_resp", bus.req_resp, 3'b001);
        step();
        bus.mem_resp = 1'b0;
        @(negedge clk);
        chk("wd_after_busy", bus.busy, 1'b0);
        chk("wd_after_err", bus.timeout_err, 1'b1);
        step();

        // Asynchronous reset in the middle of a transaction.
        bus.req_read = 3'b010;
        wait_busy();
        step();
        #2;
        bus.mem_resp = 1'b1;
        #1;
        chk("ar_pre_resp", bus.req_resp, 3'b010);
        rst_n = 1'b0;
        #1;
        chk("ar_mem_read", bus.mem_read, 1'b0);
        chk("ar_busy", bus.busy, 1'b0);
        chk("ar_req_resp", bus.req_resp, 3'b000);
        chk("ar_timeout_err", bus.timeout_err, 1'b0);
        bus.mem_resp = 1'b0;
        bus.req_read = 3'b111;
        step();
        rst_n = 1'b1;
        wait_busy();
        @(negedge clk);
        chk("ar_first_grant", bus.grant_id, 2'd0);
        step();
        bus.mem_resp = 1'b1;
        step();
        bus.mem_resp = 1'b0;

        // Randomized traffic, including stray responses and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            bus.req_read  = NUM_REQ'($urandom_range(0, 7));
            bus.req_write = ($urandom_range(0, 3) == 0) ? NUM_REQ'($urandom_range(0, 7)) : '0;
            bus.req_addr  = (NUM_REQ*ADDR_W)'({$urandom, $urandom});
            for (int j = 0; j < 12; j++) bus.req_wdata[j*32 +: 32] = $urandom;
            bus.mem_resp  = ($urandom_range(0, 2) == 0);
            bus.mem_rdata = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 499) == 0) begin
                #2;
                rst_n = 1'b0;
                #4;
                rst_n = 1'b1;
            end
            step();
        end

        cmp_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
